// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter and run-control sequencer for the single-cycle 16-bit core.
//   Holds the PC, decides each cycle whether the instruction at PC commits,
//   resolves conditional branches from the decoder's BS/OFF fields and the
//   ALU Z/N flags, handles HALT, gates the register-file and memory write
//   strobes, and counts retired instructions.
//
// Parameters
//   PC_W      PC width in bits (word addressed), 7..16
//   RESET_PC  PC value loaded on reset and on RESTART
//   CNT_W     retired-instruction counter width
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   RESET_N   synchronous active-low reset
//   START     level: high = free-run, low = stop after current instruction
//   STEP      pulse: execute exactly one instruction from IDLE
//   RESTART   pulse: leave HALTED, reload PC and clear RETIRED
//   BS        branch select: 0 BEQ, 1 BNE, 2 BGEZ, 3 BLTZ, others none
//   OFF       signed branch offset in instructions
//   HALT      decoder HALT flag
//   LD, MW    decoder register-write / memory-write requests
//   Z, N      ALU zero / negative flags for the current instruction
//   PC        current instruction address
//   EXEC      instruction at PC commits this cycle
//   LD_EN     LD gated by EXEC
//   MW_EN     MW gated by EXEC
//   BR_TAKEN  EXEC and branch condition true
//   HALTED    high in the HALTED state
//   RETIRED   saturating count of committed instructions
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic             STEP,
   input  logic             RESTART,
   input  logic [3:0]       BS,
   input  logic [5:0]       OFF,
   input  logic             HALT,
   input  logic             LD,
   input  logic             MW,
   input  logic             Z,
   input  logic             N,
   output logic [PC_W-1:0]  PC,
   output logic             EXEC,
   output logic             LD_EN,
   output logic             MW_EN,
   output logic             BR_TAKEN,
   output logic             HALTED,
   output logic [CNT_W-1:0] RETIRED
);

   typedef enum logic [1:0] {
      st_idle,
      st_run,
      st_step,
      st_halted
   } state_t;

   state_t           state, state_nxt;
   logic [PC_W-1:0]  pc_q, pc_nxt;
   logic [PC_W-1:0]  off_ext;
   logic [CNT_W-1:0] ret_q, ret_nxt;
   logic             exec;
   logic             br_cond;

   assign off_ext = {{(PC_W-6){OFF[5]}}, OFF};

   always_comb begin
      br_cond = 1'b0;
      case (BS)
         4'd0:    br_cond = Z;
         4'd1:    br_cond = ~Z;
         4'd2:    br_cond = ~N;
         4'd3:    br_cond = N;
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      ret_nxt   = ret_q;
      exec      = (state == st_run) || (state == st_step);

      case (state)
         st_idle: begin
            if (START)     state_nxt = st_run;
            else if (STEP) state_nxt = st_step;
         end
         st_run: begin
            if (HALT)        state_nxt = st_halted;
            else if (!START) state_nxt = st_idle;
         end
         st_step: begin
            state_nxt = HALT ? st_halted : st_idle;
         end
         st_halted: begin
            if (RESTART) state_nxt = st_idle;
         end
         default: state_nxt = st_idle;
      endcase

      if (exec) begin
         if (ret_q != '1) ret_nxt = ret_q + CNT_W'(1);
         // HALT holds the PC on the HALT instruction, even if BS claims a branch.
         if (!HALT) begin
            if (br_cond) pc_nxt = pc_q + PC_W'(1) + off_ext;
            else         pc_nxt = pc_q + PC_W'(1);
         end
      end

      if ((state == st_halted) && RESTART) begin
         pc_nxt  = RESET_PC;
         ret_nxt = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state <= st_idle;
         pc_q  <= RESET_PC;
         ret_q <= '0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
         ret_q <= ret_nxt;
      end
   end

   assign PC       = pc_q;
   assign EXEC     = exec;
   assign LD_EN    = LD & exec;
   assign MW_EN    = MW & exec;
   assign BR_TAKEN = exec & br_cond;
   assign HALTED   = (state == st_halted);
   assign RETIRED  = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int PC_W    = 8;
   localparam int CNT_W   = 8;
   localparam int PC_MOD  = 256;
   localparam int CNT_MAX = 255;

   logic             CLK = 1'b0;
   logic             rst_n, start, step, restart, halt, ld, mw, z, n;
   logic [3:0]       bs;
   logic [5:0]       off;
   logic [PC_W-1:0]  pc;
   logic             exec, ld_en, mw_en, br_taken, halted;
   logic [CNT_W-1:0] retired;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 idle, 1 run, 2 single step, 3 halted
   int m_st  = 0;
   int m_pc  = 0;
   int m_ret = 0;

   always #5 CLK = ~CLK;

   pc_sequencer #(
      .PC_W    (PC_W),
      .RESET_PC(8'h00),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK     (CLK),
      .RESET_N (rst_n),
      .START   (start),
      .STEP    (step),
      .RESTART (restart),
      .BS      (bs),
      .OFF     (off),
      .HALT    (halt),
      .LD      (ld),
      .MW      (mw),
      .Z       (z),
      .N       (n),
      .PC      (pc),
      .EXEC    (exec),
      .LD_EN   (ld_en),
      .MW_EN   (mw_en),
      .BR_TAKEN(br_taken),
      .HALTED  (halted),
      .RETIRED (retired)
   );

   function automatic bit ref_taken(int bs_v, bit z_v, bit n_v);
      case (bs_v)
         0:       return z_v;
         1:       return !z_v;
         2:       return !n_v;
         3:       return n_v;
         default: return 1'b0;
      endcase
   endfunction

   function bit ref_exec();
      return (m_st == 1) || (m_st == 2);
   endfunction

   // Advance model with the current inputs, then the clock edge.
   task tick();
      int nst, npc, nret;
      nst  = m_st;
      npc  = m_pc;
      nret = m_ret;
      if (!rst_n) begin
         nst = 0; npc = 0; nret = 0;
      end else begin
         if (ref_exec()) begin
            if (nret < CNT_MAX) nret = nret + 1;
            if (!halt) begin
               npc = m_pc + 1;
               if (ref_taken(int'(bs), z, n)) npc = npc + int'($signed(off));
               npc = ((npc % PC_MOD) + PC_MOD) % PC_MOD;
            end
         end
         case (m_st)
            0: nst = start ? 1 : (step ? 2 : 0);
            1: nst = halt ? 3 : (!start ? 0 : 1);
            2: nst = halt ? 3 : 0;
            default: if (restart) begin nst = 0; npc = 0; nret = 0; end
         endcase
      end
      @(posedge CLK);
      #1;
      m_st = nst; m_pc = npc; m_ret = nret;
   endtask

   task do_reset();
      rst_n = 1'b0; start = 1'b0; step = 1'b0; restart = 1'b0; halt = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Free-run with non-branch instructions until the model is in RUN at target.
   task run_to(input int target);
      int cnt;
      rst_n = 1'b1; start = 1'b1; step = 1'b0; restart = 1'b0; halt = 1'b0; bs = 4'd4;
      cnt = 0;
      while (!(m_st == 1 && m_pc == target) && cnt < 600) begin
         ld = 1'($urandom); mw = 1'($urandom); off = 6'($urandom);
         z = 1'($urandom); n = 1'($urandom);
         tick();
         cnt++;
      end
      checks++;
      if (pc !== PC_W'(target) || exec !== 1'b1) begin
         errors++;
         $display("FAIL run_to: pc=%0d exec=%0b required pc=%0d exec=1", pc, exec, target);
      end
   endtask

   task test_reset();
      rst_n = 1'b0; start = 1'b1; step = 1'b1; ld = 1'b1; mw = 1'b1;
      bs = 4'd0; z = 1'b1; n = 1'b0; off = 6'd3; halt = 1'b0; restart = 1'b0;
      tick(); tick();
      checks++;
      if (pc !== 8'd0 || retired !== 8'd0) begin
         errors++;
         $display("FAIL reset_regs: pc=%0d retired=%0d required 0 0", pc, retired);
      end
      checks++;
      if ({exec, ld_en, mw_en, br_taken, halted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: exec/ld/mw/br/halted=%b required 00000",
                  {exec, ld_en, mw_en, br_taken, halted});
      end
      start = 1'b0; step = 1'b0;
   endtask

   task test_run();
      rst_n = 1'b1; start = 1'b1; bs = 4'd4; halt = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         ld = 1'($urandom); mw = 1'($urandom); off = 6'($urandom);
         #1;
         checks++;
         if (pc !== PC_W'(i) || exec !== 1'b1 || ld_en !== ld || mw_en !== mw || br_taken !== 1'b0) begin
            errors++;
            $display("FAIL run_cycle%0d: pc=%0d exec=%0b ld_en=%0b mw_en=%0b br=%0b required pc=%0d exec=1 ld_en=%0b mw_en=%0b br=0",
                     i, pc, exec, ld_en, mw_en, br_taken, i, ld, mw);
         end
         tick();
      end
      checks++;
      if (pc !== 8'd5 || retired !== 8'd5) begin
         errors++;
         $display("FAIL run_end: pc=%0d retired=%0d required 5 5", pc, retired);
      end
   endtask

   task test_branch();
      run_to(10);
      bs = 4'd0; z = 1'b1; off = 6'b111100;
      #1;
      checks++;
      if (br_taken !== 1'b1) begin
         errors++;
         $display("FAIL beq_taken: br_taken=%0b required 1", br_taken);
      end
      tick();
      checks++;
      if (pc !== 8'd7) begin
         errors++;
         $display("FAIL beq_target: pc=%0d required 7", pc);
      end
      run_to(10);
      bs = 4'd0; z = 1'b0; off = 6'b111100;
      #1;
      checks++;
      if (br_taken !== 1'b0) begin
         errors++;
         $display("FAIL beq_not_taken: br_taken=%0b required 0", br_taken);
      end
      tick();
      checks++;
      if (pc !== 8'd11) begin
         errors++;
         $display("FAIL beq_fallthrough: pc=%0d required 11", pc);
      end
      run_to(20);
      bs = 4'd3; n = 1'b1; off = 6'd5;
      #1;
      checks++;
      if (br_taken !== 1'b1) begin
         errors++;
         $display("FAIL bltz_taken: br_taken=%0b required 1", br_taken);
      end
      tick();
      checks++;
      if (pc !== 8'd26) begin
         errors++;
         $display("FAIL bltz_target: pc=%0d required 26", pc);
      end
   endtask

   task test_halt();
      do_reset();
      run_to(8);
      halt = 1'b1; bs = 4'd0; z = 1'b1; off = 6'd9;
      tick();
      halt = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b1 || pc !== 8'd8 || exec !== 1'b0 || retired !== 8'd9) begin
         errors++;
         $display("FAIL halt_entry: halted=%0b pc=%0d exec=%0b retired=%0d required 1 8 0 9",
                  halted, pc, exec, retired);
      end
      ld = 1'b1; mw = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start = 1'(i % 2); step = 1'((i + 1) % 2);
         #1;
         checks++;
         if (halted !== 1'b1 || pc !== 8'd8 || retired !== 8'd9 || exec !== 1'b0 ||
             ld_en !== 1'b0 || mw_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold%0d: halted=%0b pc=%0d retired=%0d exec=%0b ld_en=%0b mw_en=%0b required 1 8 9 0 0 0",
                     i, halted, pc, retired, exec, ld_en, mw_en);
         end
         tick();
      end
      start = 1'b1; step = 1'b0; restart = 1'b1;
      tick();
      restart = 1'b0; start = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0 || pc !== 8'd0 || retired !== 8'd0 || exec !== 1'b0) begin
         errors++;
         $display("FAIL restart: halted=%0b pc=%0d retired=%0d exec=%0b required 0 0 0 0",
                  halted, pc, retired, exec);
      end
   endtask

   task test_step();
      start = 1'b0; step = 1'b0; ld = 1'b1; mw = 1'b1; bs = 4'd4; halt = 1'b0;
      tick();
      checks++;
      if (ld_en !== 1'b0 || mw_en !== 1'b0 || exec !== 1'b0) begin
         errors++;
         $display("FAIL idle_gating: ld_en=%0b mw_en=%0b exec=%0b required 0 0 0", ld_en, mw_en, exec);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      #1;
      checks++;
      if (exec !== 1'b1 || ld_en !== 1'b1 || mw_en !== 1'b1 || pc !== 8'd0) begin
         errors++;
         $display("FAIL step_exec: exec=%0b ld_en=%0b mw_en=%0b pc=%0d required 1 1 1 0",
                  exec, ld_en, mw_en, pc);
      end
      tick();
      tick();
      checks++;
      if (exec !== 1'b0 || pc !== 8'd1 || retired !== 8'd1) begin
         errors++;
         $display("FAIL step_done: exec=%0b pc=%0d retired=%0d required 0 1 1", exec, pc, retired);
      end
      start = 1'b1; step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      checks++;
      if (exec !== 1'b1 || pc !== 8'd2) begin
         errors++;
         $display("FAIL start_priority: exec=%0b pc=%0d required 1 2", exec, pc);
      end
      start = 1'b0;
      tick();
      checks++;
      if (exec !== 1'b0 || pc !== 8'd3) begin
         errors++;
         $display("FAIL stop_after: exec=%0b pc=%0d required 0 3", exec, pc);
      end
   endtask

   task test_wrap();
      do_reset();
      run_to(255);
      start = 1'b0; bs = 4'd4;
      #1;
      checks++;
      if (exec !== 1'b1) begin
         errors++;
         $display("FAIL wrap_last_exec: exec=%0b required 1", exec);
      end
      tick();
      tick();
      checks++;
      if (pc !== 8'd0 || exec !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL wrap_stop: pc=%0d exec=%0b halted=%0b required 0 0 0", pc, exec, halted);
      end
   endtask

   task test_reset_mid();
      do_reset();
      run_to(40);
      checks++;
      if (retired !== 8'd40) begin
         errors++;
         $display("FAIL mid_retired: retired=%0d required 40", retired);
      end
      rst_n = 1'b0; ld = 1'b1; mw = 1'b1; bs = 4'd0; z = 1'b1;
      tick();
      checks++;
      if (pc !== 8'd0 || retired !== 8'd0 ||
          {exec, ld_en, mw_en, br_taken, halted} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid: pc=%0d retired=%0d strobes=%b required 0 0 00000",
                  pc, retired, {exec, ld_en, mw_en, br_taken, halted});
      end
      rst_n = 1'b1;
   endtask

   task test_saturate();
      do_reset();
      start = 1'b1; bs = 4'd4; halt = 1'b0;
      for (int i = 0; i < 300; i++) tick();
      checks++;
      if (retired !== 8'hFF) begin
         errors++;
         $display("FAIL saturate: retired=%0d required 255", retired);
      end
   endtask

   task test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         start   = ($urandom_range(0, 3) != 0);
         step    = ($urandom_range(0, 3) == 0);
         restart = ($urandom_range(0, 7) == 0);
         halt    = ($urandom_range(0, 31) == 0);
         bs      = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
         off     = 6'($urandom);
         ld      = 1'($urandom); mw = 1'($urandom);
         z       = 1'($urandom); n  = 1'($urandom);
         #1;
         checks++;
         if (pc !== PC_W'(m_pc) || retired !== CNT_W'(m_ret) || exec !== ref_exec() ||
             ld_en !== (ld && ref_exec()) || mw_en !== (mw && ref_exec()) ||
             br_taken !== (ref_exec() && ref_taken(int'(bs), z, n)) || halted !== (m_st == 3)) begin
            errors++;
            $display("FAIL random%0d: pc=%0d ret=%0d exec=%0b ld_en=%0b mw_en=%0b br=%0b halted=%0b required pc=%0d ret=%0d exec=%0b ld_en=%0b mw_en=%0b br=%0b halted=%0b",
                     i, pc, retired, exec, ld_en, mw_en, br_taken, halted,
                     m_pc, m_ret, ref_exec(), ld && ref_exec(), mw && ref_exec(),
                     ref_exec() && ref_taken(int'(bs), z, n), m_st == 3);
         end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; step = 1'b0; restart = 1'b0; halt = 1'b0;
      ld = 1'b0; mw = 1'b0; z = 1'b0; n = 1'b0; bs = 4'd4; off = 6'd0;
      test_reset();
      test_run();
      test_branch();
      test_halt();
      test_step();
      test_wrap();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and run-control sequencer for the single-cycle 16-bit processor. It holds the PC and decides, on each clock, whether the instruction at PC executes. It resolves branches from the decoder's BS/OFF fields and the ALU Z/N flags, and handles HALT. It gates the register-file and memory write strobes so that nothing commits while the core is stopped. It also provides run, single-step and restart control plus a retired-instruction counter.

Parameters:
PC_W, 8, PC width in bits; word (instruction) addressed; legal range 7..16
RESET_PC, 0, PC value loaded on reset and on RESTART
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  input  1  clock; all state changes on its rising edge
RESET_N  input  1  synchronous, active-low reset
START  input  1  level; high = free-run, low = stop after the current instruction
STEP  input  1  one-cycle pulse; executes exactly one instruction from IDLE
RESTART  input  1  one-cycle pulse; leaves HALTED
BS  input  4  branch select from decoder: 0 BEQ, 1 BNE, 2 BGEZ, 3 BLTZ, 4 none
OFF  input  6  signed branch offset in instructions, two's complement
HALT  input  1  decoder HALT flag
LD  input  1  decoder register-write request
MW  input  1  decoder memory-write request
Z  input  1  ALU zero flag, same cycle
N  input  1  ALU negative flag, same cycle
PC  output  PC_W  current instruction address
EXEC  output  1  instruction at PC commits this cycle
LD_EN  output  1  LD and EXEC
MW_EN  output  1  MW and EXEC
BR_TAKEN  output  1  EXEC and branch condition true
HALTED  output  1  high in HALTED state
RETIRED  output  CNT_W  count of committed instructions

Behaviour:
- Synchronous reset (RESET_N=0 at an edge):
  - state=IDLE, PC=RESET_PC, RETIRED=0.
  - Consequently EXEC, LD_EN, MW_EN, BR_TAKEN and HALTED are all 0.
  - Reset overrides every other input, including mid-RUN and in HALTED.
- States are IDLE, RUN, STEP_S and HALTED.
  - EXEC is Moore: it is 1 in RUN and STEP_S, and 0 otherwise.
- Transitions, evaluated at each rising edge:
  - IDLE: START=1 -> RUN; else STEP=1 -> STEP_S; else stay. START has priority over a simultaneous STEP.
  - RUN: HALT=1 -> HALTED; else START=0 -> IDLE; else stay.
  - STEP_S: HALT=1 -> HALTED; else -> IDLE. START and STEP are ignored in this state.
  - HALTED: RESTART=1 -> IDLE and PC<=RESET_PC; else stay. START and STEP are ignored.
- PC update occurs only on edges where EXEC=1:
  - HALT=1: PC is unchanged, so it stays at the HALT instruction.
  - Branch taken: PC <= PC + 1 + sext(OFF).
  - Otherwise: PC <= PC + 1.
  - All arithmetic is modulo 2^PC_W; OFF is sign-extended to PC_W bits. Wrap from all-ones to 0 is legal.
- Branch condition:
  - BS=0: taken if Z. BS=1: taken if !Z. BS=2: taken if !N. BS=3: taken if N.
  - BS=4 and BS=5..15: not taken.
  - BR_TAKEN is combinational and is 0 whenever EXEC=0.
- The instruction in the last RUN cycle before START falls still commits; the stop takes effect at the following edge.
- LD_EN and MW_EN are combinational ANDs with EXEC, so no register or memory write occurs in IDLE or HALTED.
- RETIRED:
  - Increments by 1 on every edge with EXEC=1; the HALT instruction counts.
  - Saturates at all-ones.
  - Cleared on reset and on RESTART.
- HALT with BS indicating a branch cannot occur from the decoder; if it does, HALT wins and PC is held.

Test Plan:
- Reset then free-run: release reset, START=1 with non-branch instructions (BS=4) for 5 cycles -> PC 0,1,2,3,4,5; EXEC=1 from the first RUN cycle; RETIRED=5.
- Branch resolution:
  - At PC=10, BS=0, Z=1, OFF=6'b111100 (-4) -> BR_TAKEN=1, next PC=7.
  - Same with Z=0 -> next PC=11.
  - BS=3, N=1, OFF=5 at PC=20 -> next PC=26.
- Halt and restart:
  - HALT=1 at PC=8 in RUN -> HALTED=1, PC stays 8, EXEC=0 thereafter, RETIRED increments once for the HALT.
  - STEP and START while halted -> no change.
  - RESTART pulse -> IDLE, PC=0, RETIRED=0.
- Single-step:
  - In IDLE with START=0, STEP pulse, LD=1, MW=1 -> exactly one cycle with EXEC=1, LD_EN=1, MW_EN=1; PC advances by 1; back to IDLE.
  - LD=1 held in IDLE -> LD_EN=0.
  - START and STEP together in IDLE -> RUN entered.
- Stop and wrap: PC_W=8, RUN at PC=255 with BS=4, then START=0 -> instruction at 255 commits, PC wraps to 0, state IDLE, EXEC=0.
- Reset mid-operation: RESET_N=0 while in RUN at PC=40 with RETIRED=40 -> next edge PC=0, RETIRED=0, IDLE, all strobes 0.
